// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and receive results of uart_rx.
// The master drives the line and configuration; the slave (receiver) returns results.
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic             RX_IN;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic [WIDTH-1:0] P_DATA;
    logic             data_valid;
    logic             par_err;
    logic             stp_err;
    logic             busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority vote, optional parity
// and one-cycle data_valid / par_err / stp_err pulses.
module uart_rx #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 8
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int MID = PRESCALE / 2;
    localparam int CW  = $clog2(PRESCALE);
    localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] L_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] L_S1   = CW'(MID);
    localparam logic [CW-1:0] L_S2   = CW'(MID + 1);
    localparam logic [CW-1:0] L_WRAP = CW'(PRESCALE - 1);
    localparam logic [BW-1:0] L_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           r_state, w_next;
    logic             r_sync1, r_sync2, r_prev;
    logic [2:0]       r_warm;
    logic [CW-1:0]    r_edge_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift, r_p_data;
    logic             r_s0, r_s1;
    logic             r_par_en, r_par_typ, r_par_flag;
    logic             r_dv, r_pe, r_se;
    logic             w_rx_s, w_fall, w_sample, w_wrap, w_vote, w_par_exp;
    logic             w_done, w_dv_n, w_pe_n, w_se_n;

    assign w_rx_s    = r_sync2;
    // r_warm keeps reset-value flops from faking a falling edge when the line is already low
    assign w_fall    = r_warm[2] & r_prev & ~w_rx_s;
    assign w_sample  = r_edge_cnt == L_S2;
    assign w_wrap    = r_edge_cnt == L_WRAP;
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_par_exp = ^r_shift ^ r_par_typ;

    assign bus.P_DATA     = r_p_data;
    assign bus.data_valid = r_dv;
    assign bus.par_err    = r_pe;
    assign bus.stp_err    = r_se;
    assign bus.busy       = r_state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_warm  <= '0;
        end else begin
            r_sync1 <= bus.RX_IN;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_warm  <= {r_warm[1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // The stop decision uses the live third sample so the pulse lands as busy drops
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            IDLE:    w_next = w_fall ? START : IDLE;
            START:   w_next = (w_sample && w_vote) ? IDLE : (w_wrap ? DATA : START);
            DATA:    w_next = (w_wrap && r_bit_cnt == L_LAST) ? (r_par_en ? PARITY : STOP) : DATA;
            PARITY:  w_next = w_wrap ? STOP : PARITY;
            STOP: begin
                w_next = w_sample ? IDLE : STOP;
                w_done = w_sample;
            end
            default: w_next = IDLE;
        endcase
        w_se_n = w_done & ~w_vote;
        w_pe_n = w_done & w_vote & r_par_flag;
        w_dv_n = w_done & w_vote & ~r_par_flag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_p_data   <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_flag <= 1'b0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_dv <= w_dv_n;
            r_pe <= w_pe_n;
            r_se <= w_se_n;
            if (w_dv_n) r_p_data <= r_shift;
            r_edge_cnt <= (r_state == IDLE || w_wrap) ? '0 : r_edge_cnt + 1'b1;
            if (r_edge_cnt == L_S0) r_s0 <= w_rx_s;
            if (r_edge_cnt == L_S1) r_s1 <= w_rx_s;
            if (r_state == IDLE && w_fall) begin
                r_par_en   <= bus.PAR_EN;
                r_par_typ  <= bus.PAR_TYP;
                r_par_flag <= 1'b0;
            end
            if (r_state == DATA && w_sample) r_shift <= WIDTH'({w_vote, r_shift} >> 1);
            if (r_state == DATA && w_wrap) r_bit_cnt <= (r_bit_cnt == L_LAST) ? '0 : r_bit_cnt + 1'b1;
            if (r_state == PARITY && w_sample && w_vote != w_par_exp) r_par_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame table, random frames against a frame-level reference,
// plus glitch, back-to-back and reset corner sequences for uart_rx.
module tb_uart_rx;
    localparam int W   = 8;
    localparam int P   = 8;
    localparam int MID = P / 2;

    typedef struct {
        logic [W-1:0] d;
        bit           pen, ptyp, pbit, sbit;
        int           kind;
        logic [W-1:0] pdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0, n_err = 0;
    int   n_dv = 0, n_pe = 0, n_se = 0;
    int   last_pulse = -1;
    logic [W-1:0] dv_data[$];
    int   dv_cyc[$];
    logic [W-1:0] ref_pdata = '0;

    uart_rx_if #(.WIDTH(W)) bus();
    uart_rx #(.WIDTH(W), .PRESCALE(P)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.data_valid || bus.par_err || bus.stp_err) begin
            check("one_pulse", 32'(bus.data_valid) + 32'(bus.par_err) + 32'(bus.stp_err), 1);
            check("busy_low_at_pulse", bus.busy, 0);
            last_pulse = cyc;
            if (bus.data_valid) begin
                n_dv++;
                dv_data.push_back(bus.P_DATA);
                dv_cyc.push_back(cyc);
            end
            if (bus.par_err) n_pe++;
            if (bus.stp_err) n_se++;
        end
    end

    // Outcome of a frame from line-level rules: 0 good, 1 parity error, 2 stop error
    function automatic int ref_kind(input logic [W-1:0] d, input bit pen, input bit ptyp,
                                    input bit pbit, input bit sbit);
        if (!sbit) return 2;
        if (pen && (($countones(d) + int'(pbit)) % 2) != int'(ptyp)) return 1;
        return 0;
    endfunction

    task automatic drive_bit(input logic b);
        bus.RX_IN = b;
        repeat (P) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit pen, input bit ptyp,
                              input bit pbit, input bit sbit, output int t0);
        bus.PAR_EN  = pen;
        bus.PAR_TYP = ptyp;
        t0 = cyc;
        drive_bit(1'b0);
        bus.PAR_EN  = 1'($urandom_range(0, 1));
        bus.PAR_TYP = 1'($urandom_range(0, 1));
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(sbit);
        bus.RX_IN = 1'b1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int dv0 = n_dv, pe0 = n_pe, se0 = n_se, t0;
        send_frame(v.d, v.pen, v.ptyp, v.pbit, v.sbit, t0);
        repeat (2 * P) @(negedge clk);
        check({tag, "_dv"}, n_dv - dv0, v.kind == 0);
        check({tag, "_pe"}, n_pe - pe0, v.kind == 1);
        check({tag, "_se"}, n_se - se0, v.kind == 2);
        check({tag, "_pdata"}, bus.P_DATA, v.pdata);
        check({tag, "_latency"}, last_pulse - (t0 + 1), (W + 1 + int'(v.pen)) * P + MID + 4);
        check({tag, "_busy_idle"}, bus.busy, 0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   t0, t1, b, dv0, pe0, se0;
        tbl[0] = '{8'hA5, 0, 0, 0, 1, 0, 8'hA5};
        tbl[1] = '{8'h3C, 1, 0, 0, 1, 0, 8'h3C};
        tbl[2] = '{8'h3C, 1, 0, 1, 1, 1, 8'h3C};
        tbl[3] = '{8'h55, 0, 0, 0, 0, 2, 8'h3C};
        tbl[4] = '{8'h07, 1, 1, 0, 1, 0, 8'h07};
        tbl[5] = '{8'h07, 1, 1, 1, 1, 1, 8'h07};
        tbl[6] = '{8'hFF, 1, 0, 1, 0, 2, 8'h07};
        tbl[7] = '{8'h00, 0, 1, 1, 1, 0, 8'h00};

        bus.RX_IN = 1'b1;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pdata", bus.P_DATA, 0);
        check("rst_dv", bus.data_valid, 0);
        check("rst_pe", bus.par_err, 0);
        check("rst_se", bus.stp_err, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec($sformatf("dir%0d", i), tbl[i]);
        ref_pdata = tbl[7].pdata;

        for (int i = 0; i < 40; i++) begin
            v.d    = W'($urandom);
            v.pen  = 1'($urandom_range(0, 1));
            v.ptyp = 1'($urandom_range(0, 1));
            v.pbit = 1'($urandom_range(0, 1));
            v.sbit = $urandom_range(0, 5) != 0;
            v.kind = ref_kind(v.d, v.pen, v.ptyp, v.pbit, v.sbit);
            if (v.kind == 0) ref_pdata = v.d;
            v.pdata = ref_pdata;
            run_vec($sformatf("rnd%0d", i), v);
        end

        dv0 = n_dv; pe0 = n_pe; se0 = n_se; b = 0;
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        bus.RX_IN = 1'b1;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (bus.busy) b++;
        end
        check("glitch_busy_seen", b > 0, 1);
        check("glitch_busy_short", b <= P, 1);
        check("glitch_no_pulse", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
        check("glitch_pdata", bus.P_DATA, ref_pdata);

        dv0 = n_dv;
        send_frame(8'h01, 0, 0, 0, 1, t0);
        send_frame(8'hFE, 0, 0, 0, 1, t1);
        repeat (2 * P) @(negedge clk);
        check("b2b_count", n_dv - dv0, 2);
        check("b2b_spacing", dv_cyc[$] - dv_cyc[$-1], 10 * P);
        check("b2b_first", dv_data[$-1], 8'h01);
        check("b2b_second", dv_data[$], 8'hFE);

        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        bus.RX_IN = 1'b0;
        repeat (MID) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_pdata", bus.P_DATA, 0);
        bus.RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3 * P) @(negedge clk);
        check("midrst_no_pulse", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
        check("midrst_idle", bus.busy, 0);
        run_vec("after_rst", '{8'h81, 0, 0, 0, 1, 0, 8'h81});

        rst = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        b = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (bus.busy) b++;
        end
        check("low_line_no_start", b, 0);
        bus.RX_IN = 1'b1;
        repeat (2 * P) @(negedge clk);
        run_vec("low_release", '{8'h5A, 1, 1, 1, 1, 0, 8'h5A});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per frame.
REQ-002 Parameter: PRESCALE, 8, clk cycles per bit period (oversampling ratio); legal values are even numbers >= 6.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-low.
REQ-005 Port: RX_IN  input  1  serial line; idles high; asynchronous to clk.
REQ-006 Port: PAR_EN  input  1  1 = the frame carries a parity bit after the data bits.
REQ-007 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 Port: P_DATA  output  WIDTH  last good received byte.
REQ-009 Port: data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 Port: par_err  output  1  one-cycle pulse on a parity mismatch.
REQ-011 Port: stp_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-012 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 RX_IN SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-015 Bit timing SHALL use edge_cnt, which counts 0..PRESCALE-1 and wraps to 0.
  - edge_cnt SHALL be cleared on entry to START.
REQ-016 Bit sampling SHALL be a majority vote of rx_s taken at edge_cnt = MID-1, MID and MID+1, where MID = PRESCALE/2.
  - The voted bit SHALL be valid from edge_cnt = MID+2.
REQ-017 IDLE -> START SHALL occur on a falling edge of rx_s (previous 1, current 0).
  - PAR_EN and PAR_TYP SHALL be latched at this transition and held for the whole frame.
REQ-018 START: if the voted bit is 1, the FSM SHALL treat it as a glitch and return to IDLE with no output pulse.
  - Otherwise the FSM SHALL go to DATA at the edge_cnt wrap.
REQ-019 DATA: WIDTH bits SHALL be received LSB first into a shift register, using bit_cnt 0..WIDTH-1.
  - After the last bit, the FSM SHALL go to PARITY if the latched PAR_EN is 1, else to STOP, at the wrap.
REQ-020 PARITY: the voted bit SHALL be compared with the XOR-reduction of the data (inverted when the latched PAR_TYP is 1).
  - The result SHALL be held in a sticky flag; the FSM SHALL go to STOP at the wrap.
REQ-021 STOP: at edge_cnt = MID+2 the FSM SHALL return to IDLE, i.e. half a bit early, so that back-to-back frames are accepted.
  - In that same cycle exactly one outcome SHALL occur:
  - stop bit 0 -> stp_err = 1 for one cycle.
  - else parity flag set -> par_err = 1 for one cycle.
  - else P_DATA <= shift register and data_valid = 1 for one cycle.
REQ-022 On a parity or stop error, P_DATA SHALL keep its previous value.
  - data_valid, par_err and stp_err SHALL be mutually exclusive.
REQ-023 A falling edge during STOP SHALL be ignored; detection SHALL resume in IDLE on the next cycle only.
REQ-024 Latency: for a frame with n bits including start and stop, data_valid SHALL rise exactly (n-1)*PRESCALE + MID + 2 + 2 cycles after the start-edge transition on RX_IN.
  - The +2 is the synchronizer delay; the bench SHALL check this count.
REQ-025 busy SHALL be combinational from the state register.

Reset
REQ-026 While rst = 0, all of the following SHALL hold:
  - FSM in IDLE, edge_cnt = 0, bit_cnt = 0, shift register = 0.
  - P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, busy = 0.
  - Both synchronizer flops = 1 (line idle).
REQ-027 A reset asserted mid-frame SHALL abort the frame with no pulse on any output.
  - After release, the block SHALL wait for a new falling edge; a line already low SHALL NOT start a frame.

Verification
REQ-028 Scenario: PRESCALE=8, PAR_EN=0; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_valid pulses once, P_DATA = 0xA5, busy drops the same cycle.
REQ-029 Scenario: PAR_EN=1, PAR_TYP=0; send 0x3C with parity bit 0 -> P_DATA = 0x3C. Repeat with parity bit 1 -> par_err pulse, P_DATA stays 0x3C.
REQ-030 Scenario: send 0x55 with the stop bit driven 0 -> stp_err pulse, no data_valid, FSM back in IDLE.
REQ-031 Scenario: 2-cycle low glitch on RX_IN -> no output pulse, busy high for at most one bit period and then low.
REQ-032 Scenario: frames 0x01 and 0xFE back-to-back with no idle gap -> two data_valid pulses exactly 10*PRESCALE cycles apart, data correct.
REQ-033 Scenario: rst asserted during DATA bit 3, then released with RX_IN high, then a frame 0x81 is sent -> no pulse before the frame, then P_DATA = 0x81.
